// File: rtl/reg_pkg.sv
// Shared definitions for the register primitives (plain, enable, reset, pipe).
// Latency: n/a (package only).
// Backpressure: n/a.
package reg_pkg;

  // Reset fill bit for data registers; replicated to the data width by users.
  localparam logic REG_INIT_BIT = 1'b0;

  // Width of an occupancy counter able to hold 0..depth+1 words.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a data register.
// Latency: 1 cycle from prev to v/d when ready.
// Backpressure: holds while next_ready=0 and full; ready = !v | next_ready.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           clears the valid bit, data holds
//   prev_v, prev_d  word offered by the upstream stage
//   next_ready      ready of the downstream stage
//   v, d, ready     stage state and this stage's ready
module reg_pipe_stage #(
  parameter int         W    = 8,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         prev_v,
  input  logic [W-1:0] prev_d,
  input  logic         next_ready,
  output logic         v,
  output logic [W-1:0] d,
  output logic         ready
);

  assign ready = !v | next_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= INIT;
    end else if (flush) begin
      v <= 1'b0;
    end else if (ready) begin
      v <= prev_v;
      // Data only moves with a real word so a bubble never overwrites it.
      if (prev_v) d <= prev_d;
    end
  end

endmodule

// File: rtl/reg_pipe.sv
// Elastic register pipeline of DEPTH valid/data stages; bubbles collapse.
// Latency: DEPTH cycles when empty with out_ready=1; 1 word/cycle throughput.
// Backpressure: combinational ready chain from out_ready, or a skid register
//               with registered in_ready when REG_PIPE_SKID_EN is defined.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 drops all held words (data registers hold)
//   in_valid/in_data/in_ready     upstream handshake
//   out_valid/out_data/out_ready  downstream handshake
//   count                 words currently held
// Build option: define REG_PIPE_SKID_EN to add the skid register.
module reg_pipe
  import reg_pkg::*;
#(
  parameter int           W     = 8,
  parameter int           DEPTH = 2,
  parameter logic [W-1:0] INIT  = {W{REG_INIT_BIT}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [W-1:0]                 in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [W-1:0]                 out_data,
  input  logic                         out_ready,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int CW = cnt_width(DEPTH);

  logic [DEPTH-1:0]        v;
  logic [DEPTH-1:0][W-1:0] d;
  logic                    s0_v;
  logic [W-1:0]            s0_d;
  logic                    rdy0;
  logic                    in_xfer;
  logic                    out_xfer;

  // Each stage keeps its ready in its own scope so the combinational chain
  // is a series of distinct nets rather than one self-referencing vector.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic         pv;
    logic [W-1:0] pd;
    logic         nr;
    logic         rdy_i;

    if (i == 0) begin : g_first
      assign pv = s0_v;
      assign pd = s0_d;
    end else begin : g_rest
      assign pv = v[i-1];
      assign pd = d[i-1];
    end

    if (i == DEPTH - 1) begin : g_last
      assign nr = out_ready;
    end else begin : g_mid
      assign nr = g_stage[i+1].rdy_i;
    end

    reg_pipe_stage #(.W(W), .INIT(INIT)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .prev_v     (pv),
      .prev_d     (pd),
      .next_ready (nr),
      .v          (v[i]),
      .d          (d[i]),
      .ready      (rdy_i)
    );
  end

  assign rdy0      = g_stage[0].rdy_i;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

`ifdef REG_PIPE_SKID_EN
  logic         sv;
  logic [W-1:0] sd;
  logic         flush_q;

  // in_ready depends only on flops, cutting the path from out_ready.
  assign in_ready = !sv & !flush_q;
  // A parked word always goes first; new words bypass an empty skid.
  assign s0_v     = sv | in_xfer;
  assign s0_d     = sv ? sd : in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      sv      <= 1'b0;
      sd      <= INIT;
      flush_q <= 1'b0;
    end else begin
      flush_q <= flush;
      if (flush) begin
        sv <= 1'b0;
      end else if (sv) begin
        if (rdy0) sv <= 1'b0;
      end else if (in_xfer && !rdy0) begin
        sv <= 1'b1;
        sd <= in_data;
      end
    end
  end
`else
  assign in_ready = rdy0 & !flush;
  assign s0_v     = in_valid;
  assign s0_d     = in_data;
`endif

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      count <= count - CW'(1);
    end
  end

endmodule
